// File: rtl/dbus_arbiter.sv
// dbus_arbiter
//   Shares the 8-bit data-memory / I-O bus between two masters: m0 (CPU) and
//   m1 (DMA/loader). Grants are combinational and round-robin. A master that
//   holds lock can keep the bus for up to MAX_BURST consecutive grants while
//   the other master is waiting. The granted address is decoded into d_ram
//   (0x0000-0x07FF) and io (0x1000-0x10FF) strobes. Read data returns one
//   cycle after the grant and is routed to the master that issued the read.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   mN_req_i / mN_lock_i         access request / keep ownership next cycle
//   mN_we_i, mN_addr_i,
//   mN_wdata_i                   access type, byte address, write data
//   mN_gnt_o                     combinational grant (access runs this cycle)
//   mN_rvalid_o, mN_rdata_o      read return, one cycle after the grant
//   bus_addr_o, bus_wdata_o      selected master address / write data
//   ram_w_en_o, ram_r_en_o,
//   ram_rdata_i                  d_ram strobes and synchronous read data
//   io_w_en_o, io_r_en_o,
//   io_rdata_i                   io strobes and synchronous read data
//   err_o                        pulse: previous granted access was unmapped
module dbus_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_lock_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [7:0]        m0_wdata_i,
  input  logic              m1_req_i,
  input  logic              m1_lock_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [7:0]        m1_wdata_i,
  output logic              m0_gnt_o,
  output logic              m1_gnt_o,
  output logic              m0_rvalid_o,
  output logic              m1_rvalid_o,
  output logic [7:0]        m0_rdata_o,
  output logic [7:0]        m1_rdata_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_wdata_o,
  output logic              ram_w_en_o,
  output logic              ram_r_en_o,
  input  logic [7:0]        ram_rdata_i,
  output logic              io_w_en_o,
  output logic              io_r_en_o,
  input  logic [7:0]        io_rdata_i,
  output logic              err_o
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_BURST - 1);
  localparam logic [ADDR_W-1:0] RAM_LAST = ADDR_W'(16'h07FF);
  localparam logic [ADDR_W-1:0] IO_FIRST = ADDR_W'(16'h1000);
  localparam logic [ADDR_W-1:0] IO_LAST  = ADDR_W'(16'h10FF);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} own_e;
  typedef enum logic [1:0] {RGN_NONE = 2'd0, RGN_RAM = 2'd1, RGN_IO = 2'd2} rgn_e;

  own_e             state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]       bus_wdata_q, bus_wdata_d;
  logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  rgn_e             rgn_q, rgn_d;
  logic             err_q, err_d;
  logic [7:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic             gnt0, gnt1, gnt_any, hold_ok;
  logic             sel_we, in_ram, in_io;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]       sel_wdata, rd_mux;
  rgn_e             sel_rgn;

  // Owner FSM and grant selection. Grants are forced low while rst is high so
  // no access can start during reset.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = IDLE;
    hold_ok = lock_q && (burst_cnt_q < CNT_MAX);
    if (!rst) begin
      case ({m0_req_i, m1_req_i})
        2'b10: gnt0 = 1'b1;
        2'b01: gnt1 = 1'b1;
        2'b11: begin
          if (state_q == OWN0 && hold_ok)      gnt0 = 1'b1;
          else if (state_q == OWN1 && hold_ok) gnt1 = 1'b1;
          else if (last_gnt_q)                 gnt0 = 1'b1;
          else                                 gnt1 = 1'b1;
        end
        default: ;
      endcase
    end
    if (gnt0)      state_d = OWN0;
    else if (gnt1) state_d = OWN1;
  end

  assign gnt_any   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? m1_we_i    : m0_we_i;
  assign sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;
  assign in_ram    = (sel_addr <= RAM_LAST);
  assign in_io     = (sel_addr >= IO_FIRST) && (sel_addr <= IO_LAST);
  assign sel_rgn   = in_ram ? RGN_RAM : (in_io ? RGN_IO : RGN_NONE);

  // Read data source is chosen by the region captured with the read grant,
  // so a new grant this cycle cannot disturb the return in flight.
  always_comb begin
    case (rgn_q)
      RGN_RAM: rd_mux = ram_rdata_i;
      RGN_IO:  rd_mux = io_rdata_i;
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    burst_cnt_d = '0;
    if ((gnt0 && state_q == OWN0) || (gnt1 && state_q == OWN1))
      burst_cnt_d = (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
    last_gnt_d  = gnt_any ? gnt1 : last_gnt_q;
    lock_d      = (gnt0 && m0_lock_i) || (gnt1 && m1_lock_i);
    bus_addr_d  = gnt_any ? sel_addr  : bus_addr_q;
    bus_wdata_d = gnt_any ? sel_wdata : bus_wdata_q;
    rvalid0_d   = gnt0 && !sel_we;
    rvalid1_d   = gnt1 && !sel_we;
    rgn_d       = (gnt_any && !sel_we) ? sel_rgn : rgn_q;
    err_d       = gnt_any && (sel_rgn == RGN_NONE);
    rdata0_d    = rvalid0_q ? rd_mux : rdata0_q;
    rdata1_d    = rvalid1_q ? rd_mux : rdata1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      lock_q      <= 1'b0;
      burst_cnt_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rgn_q       <= RGN_NONE;
      err_q       <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      lock_q      <= lock_d;
      burst_cnt_q <= burst_cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rgn_q       <= rgn_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign bus_addr_o  = bus_addr_d;
  assign bus_wdata_o = bus_wdata_d;
  assign ram_w_en_o  = gnt_any && in_ram && sel_we;
  assign ram_r_en_o  = gnt_any && in_ram && !sel_we;
  assign io_w_en_o   = gnt_any && in_io && sel_we;
  assign io_r_en_o   = gnt_any && in_io && !sel_we;
  assign m0_rvalid_o = rvalid0_q;
  assign m1_rvalid_o = rvalid1_q;
  // Delivered byte appears with rvalid; otherwise each master sees its last byte.
  assign m0_rdata_o  = rdata0_d;
  assign m1_rdata_o  = rdata1_d;
  assign err_o       = err_q;

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the 8-bit data-memory/I-O bus between two masters: m0 (CPU) and m1 (DMA/loader).
- Decodes addresses into d_ram (0x0000–0x07FF) and io (0x1000–0x10FF) strobes.
- Arbitration is round-robin, with a bounded lock for bursts.
- Returns synchronous read data one cycle after a grant, routed to the originating master.

Parameters:
- MAX_BURST, 4, maximum consecutive locked grants to one master while the other is requesting (≥1).
- ADDR_W, 16, address width.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  access request this cycle
- m0_lock / m1_lock  in  1  request to keep ownership next cycle
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  8  write data
- m0_gnt / m1_gnt  out  1  combinational grant; access executes this cycle
- m0_rvalid / m1_rvalid  out  1  read data valid (registered, 1 cycle after grant)
- m0_rdata / m1_rdata  out  8  read data, valid when rvalid
- bus_addr  out  ADDR_W  selected master address
- bus_wdata  out  8  selected master write data
- ram_w_en / ram_r_en  out  1  d_ram strobes
- ram_rdata  in  8  d_ram dout (synchronous, 1 cycle)
- io_w_en / io_r_en  out  1  io strobes
- io_rdata  in  8  io dout (synchronous, 1 cycle)
- err  out  1  registered pulse: previous cycle's granted access was unmapped

Behaviour:
- Reset values: all gnt, strobes, rvalid and err = 0; rdata = 0; bus_addr/bus_wdata = 0. Internal state: owner = 1 (m0 wins first contention), burst_cnt = 0, rd_pending = 0.
- Owner FSM states:
  - IDLE: no grant last cycle.
  - OWN0 / OWN1: mN granted last cycle.
  - next = OWN0/OWN1 on grant, else IDLE.
- Grant rules (combinational), in priority order:
  1. Only one req asserted: grant it.
  2. Both asserted, previous owner held lock last cycle, and burst_cnt < MAX_BURST−1: grant previous owner.
  3. Otherwise: grant the master not granted most recently (last_gnt register, updated on every grant).
  - Never both gnt = 1.
- burst_cnt:
  - Increments on consecutive grants to the same master, saturating at MAX_BURST−1.
  - Clears to 0 on owner change or IDLE.
  - With no competing request, the owner keeps the bus indefinitely; saturation has no effect.
- Decode, on the granted master's address:
  - 0x0000–0x07FF → ram_w_en = we, ram_r_en = !we.
  - 0x1000–0x10FF → io strobes.
  - Else no strobe; err pulses next cycle; the write is dropped and a read returns 0x00 with rvalid.
- Read return:
  - A granted read registers {master, region}.
  - The next cycle asserts that master's rvalid for exactly 1 cycle.
  - rdata is muxed from ram_rdata/io_rdata/0x00 by the registered region.
  - The other master's rdata holds its last value.
- Writes produce no rvalid.
- A read granted in cycle N+1 to a different master does not disturb cycle N's return.
- Back-to-back reads sustain 1 access/cycle.
- No grant: bus_addr/bus_wdata hold their last values; all strobes = 0.
- Reset mid-operation: a pending rvalid is squashed; no strobe is asserted while rst = 1.

Test Plan:
1. Single master:
   - m0 reads 0x0010 with ram_rdata = 0xA5 next cycle → m0_gnt = 1, ram_r_en = 1 at cycle N; m0_rvalid = 1, m0_rdata = 0xA5 at N+1; m1 outputs idle.
2. Contention round-robin:
   - Both req continuously with no lock → grants alternate m0, m1, m0, m1 starting with m0 after reset.
3. Lock burst, MAX_BURST = 4:
   - m1 granted with lock = 1 while m0 requests → m1 holds 4 consecutive grants, then m0 is granted.
   - m0 not requesting → m1 holds indefinitely.
4. Decode:
   - m0 writes 0x1003 ← 0x5A → io_w_en = 1, bus_addr = 0x1003, bus_wdata = 0x5A.
   - Write to 0x0800 → no strobe; err = 1 next cycle.
   - Read of 0x2000 → rvalid with rdata = 0x00.
5. Interleaved reads:
   - m0 reads RAM at N, m1 reads IO at N+1 → m0_rvalid at N+1 with ram data; m1_rvalid at N+2 with io data; no cross-delivery.
6. Async reset:
   - Assert rst between a read grant and its return → m0_rvalid never asserts; all outputs 0 immediately.
   - After release, m0 wins the first contention.
